// File: rtl/uart_tx_frame.sv
// UART frame transmitter: one DATA_WIDTH-bit word per handshake, sent as 8N1 bytes
// with optional header, selectable byte order and optional additive checksum.
module uart_tx_frame #(
   parameter int         CLK_FREQ    = 50_000_000,
   parameter int         BAUD        = 115200,
   parameter int         DATA_WIDTH  = 19,
   parameter bit         MSB_FIRST   = 1'b0,
   parameter bit         HEADER_EN   = 1'b1,
   parameter logic [7:0] HEADER_BYTE = 8'hA5,
   parameter bit         CHECKSUM_EN = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  uart_tx
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int NBYTES     = (DATA_WIDTH + 7) / 8;
   localparam int HDR        = HEADER_EN ? 1 : 0;
   localparam int CKS        = CHECKSUM_EN ? 1 : 0;
   localparam int NFRAME     = NBYTES + HDR + CKS;
   localparam int CW         = $clog2(BIT_CYCLES);
   localparam int BYW        = (NFRAME > 1) ? $clog2(NFRAME) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BYW-1:0] BYTE_LAST = BYW'(NFRAME - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           baud_q;
   logic [2:0]              bit_q;
   logic [BYW-1:0]          byte_q;
   logic [NBYTES-1:0][7:0]  pay_q;
   logic [7:0]              csum_q, csum_d;
   logic [NBYTES*8-1:0]     ext;
   logic [7:0]              cur_byte;
   logic                    accept, baud_end, last_byte;
   logic                    line_d, done_d, uart_tx_q, done_q;

   assign accept    = tx_valid && (state_q == IDLE);
   assign baud_end  = (baud_q == BAUD_LAST);
   assign last_byte = (byte_q == BYTE_LAST);

   // Zero-extend the payload and sum its bytes at acceptance time
   always_comb begin
      ext = '0;
      ext[DATA_WIDTH-1:0] = tx_data;
      csum_d = '0;
      for (int i = 0; i < NBYTES; i++) csum_d = csum_d + ext[8*i +: 8];
   end

   // Frame byte currently on the wire: header, payload (ordered), then checksum
   always_comb begin
      int p;
      cur_byte = csum_q;
      p = int'(byte_q) - HDR;
      if (HEADER_EN && byte_q == '0) cur_byte = HEADER_BYTE;
      else
         for (int i = 0; i < NBYTES; i++)
            if (p == (MSB_FIRST ? NBYTES - 1 - i : i)) cur_byte = pay_q[i];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         uart_tx_q <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         uart_tx_q <= line_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)                    state_d = START;
         START:   if (baud_end)                  state_d = DATA;
         DATA:    if (baud_end && bit_q == 3'd7) state_d = STOP;
         STOP:    if (baud_end)                  state_d = last_byte ? IDLE : START;
         default:                                state_d = IDLE;
      endcase
   end

   always_comb begin
      line_d = 1'b1;
      done_d = 1'b0;
      case (state_q)
         START:   line_d = 1'b0;
         DATA:    line_d = cur_byte[bit_q];
         STOP:    done_d = baud_end && last_byte;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         baud_q <= '0;
         bit_q  <= '0;
         byte_q <= '0;
         pay_q  <= '0;
         csum_q <= '0;
      end else if (accept) begin
         baud_q <= '0;
         bit_q  <= '0;
         byte_q <= '0;
         pay_q  <= ext;
         csum_q <= csum_d;
      end else if (state_q != IDLE) begin
         baud_q <= baud_end ? '0 : baud_q + 1'b1;
         if (state_q == DATA && baud_end) bit_q <= bit_q + 1'b1;
         if (state_q == STOP && baud_end) byte_q <= last_byte ? '0 : byte_q + 1'b1;
      end
   end

   assign tx_ready   = (state_q == IDLE);
   assign busy       = ~tx_ready;
   assign frame_done = done_q;
   assign uart_tx    = uart_tx_q;

endmodule
